// File: rtl/full_subtractor_pkg.sv
// Reset values shared by the subtractor output register stage.
// Constants only; no logic.
package full_subtractor_pkg;

    localparam logic DIFF_RST   = 1'b0;
    localparam logic BORROW_RST = 1'b0;

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with bout as the borrow to the next bit.
// Latency 0 (combinational); no backpressure.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/full_subtractor.sv
// Ripple-borrow subtractor {borrow, diff} = a - b - c; latency 1 cycle if REG_OUT else 0.
// No backpressure: a new operand is accepted every cycle.
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic             borrow,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH:0]   bin_chain;
    logic [WIDTH-1:0] diff_comb;

    assign bin_chain[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (bin_chain[i]),
            .d    (diff_comb[i]),
            .bout (bin_chain[i+1])
        );
    end

    if (REG_OUT) begin : g_reg
        logic             borrow_q;
        logic [WIDTH-1:0] diff_q;

        // Reset wins over the incoming operand, dropping any in-flight result.
        always_ff @(posedge clk) begin
            if (rst) begin
                borrow_q <= BORROW_RST;
                diff_q   <= {WIDTH{DIFF_RST}};
            end else begin
                borrow_q <= bin_chain[WIDTH];
                diff_q   <= diff_comb;
            end
        end

        assign borrow = borrow_q;
        assign diff   = diff_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign borrow = bin_chain[WIDTH];
        assign diff   = diff_comb;
    end

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and randomised checks of full_subtractor in 1-bit and 8-bit, combinational and registered forms.
module tb_full_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       c8 = 1'b0;

    logic       w1c_borrow, w1c_diff, w1r_borrow, w1r_diff;
    logic       w8c_borrow, w8r_borrow;
    logic [7:0] w8c_diff, w8r_diff;

    int total = 0;
    int bad   = 0;

    // Expected {borrow, diff} indexed by {a, b, c}.
    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11};

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_w1c (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .borrow(w1c_borrow), .diff(w1c_diff));
    full_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_w1r (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .borrow(w1r_borrow), .diff(w1r_diff));
    full_subtractor #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .borrow(w8c_borrow), .diff(w8c_diff));
    full_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .c(c8), .borrow(w8r_borrow), .diff(w8r_diff));

    task automatic test_reset;
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        a8 = 8'hA5; b8 = 8'h11; c8 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({w1r_borrow, w1r_diff} !== 2'b00) begin
            bad++;
            $display("FAIL reset_w1 got=%b want=00", {w1r_borrow, w1r_diff});
        end
        total++;
        if ({w8r_borrow, w8r_diff} !== 9'h000) begin
            bad++;
            $display("FAIL reset_w8 got=%h want=000", {w8r_borrow, w8r_diff});
        end
    endtask

    task automatic test_truth_table;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = i[2:0];
            {a1, b1, c1} = v;
            #100;
            total++;
            if ({w1c_borrow, w1c_diff} !== tt[i]) begin
                bad++;
                $display("FAIL truth_table abc=%b got=%b want=%b", v, {w1c_borrow, w1c_diff}, tt[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        rst = 1'b0;
        {a1, b1, c1} = 3'b011;
        @(posedge clk); #1;
        {a1, b1, c1} = 3'b100;
        total++;
        if ({w1r_borrow, w1r_diff} !== 2'b10) begin
            bad++;
            $display("FAIL b2b_011 got=%b want=10", {w1r_borrow, w1r_diff});
        end
        @(posedge clk); #1;
        total++;
        if ({w1r_borrow, w1r_diff} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_100 got=%b want=01", {w1r_borrow, w1r_diff});
        end
    endtask

    task automatic test_mid_reset;
        rst = 1'b1;
        {a1, b1, c1} = 3'b111;
        @(posedge clk); #1;
        total++;
        if ({w1r_borrow, w1r_diff} !== 2'b00) begin
            bad++;
            $display("FAIL rst_hold got=%b want=00", {w1r_borrow, w1r_diff});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({w1r_borrow, w1r_diff} !== 2'b11) begin
            bad++;
            $display("FAIL rst_release got=%b want=11", {w1r_borrow, w1r_diff});
        end
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({w1r_borrow, w1r_diff} !== 2'b00) begin
            bad++;
            $display("FAIL rst_mid got=%b want=00", {w1r_borrow, w1r_diff});
        end
        rst = 1'b0;
    endtask

    task automatic test_w8_vectors;
        logic [7:0] va [4] = '{8'h05, 8'h00, 8'hFF, 8'h80};
        logic [7:0] vb [4] = '{8'h03, 8'hFF, 8'hFF, 8'h01};
        logic       vc [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [8:0] ve [4] = '{9'h001, 9'h100, 9'h000, 9'h07F};
        for (int i = 0; i < 4; i++) begin
            a8 = va[i]; b8 = vb[i]; c8 = vc[i];
            #1;
            total++;
            if ({w8c_borrow, w8c_diff} !== ve[i]) begin
                bad++;
                $display("FAIL w8_comb[%0d] got=%h want=%h", i, {w8c_borrow, w8c_diff}, ve[i]);
            end
            @(posedge clk); #1;
            total++;
            if ({w8r_borrow, w8r_diff} !== ve[i]) begin
                bad++;
                $display("FAIL w8_reg[%0d] got=%h want=%h", i, {w8r_borrow, w8r_diff}, ve[i]);
            end
        end
    endtask

    task automatic test_w8_random;
        logic [8:0] expected;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        for (int n = 0; n < 1200; n++) begin
            expected = {1'b0, a8} - {1'b0, b8} - {8'h00, c8};
            @(posedge clk); #1;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            total++;
            if ({w8r_borrow, w8r_diff} !== expected) begin
                bad++;
                $display("FAIL w8_random[%0d] got=%h want=%h", n, {w8r_borrow, w8r_diff}, expected);
            end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_back_to_back();
        test_mid_reset();
        test_w8_vectors();
        test_w8_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
